// File: rtl/musicbox_pkg.sv
// Shared definitions for the polyphonic-input tone generator: pitch table,
// half-period arithmetic and FSM state encoding.
package musicbox_pkg;

    localparam int NUM_NOTES = 16;

    localparam int BASE_HZ [0:NUM_NOTES-1] = '{
        1865, 1976, 2093, 2217, 2349, 2489, 2637, 2794,
        2960, 3136, 3322, 3520, 3729, 3951, 4186, 4434
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        SUSTAIN = 2'd2
    } state_e;

    // Floor division happens before the band shift.
    function automatic longint half_period(input longint clk_hz, input int idx, input int band);
        longint hp;
        hp = clk_hz / (2 * longint'(BASE_HZ[idx]));
        return hp << band;
    endfunction

    // Worst case is the lowest pitch (entry 0) at the top band.
    function automatic int period_w(input longint clk_hz, input int band_w);
        longint v;
        int     w;
        v = half_period(clk_hz, 0, (1 << band_w) - 1);
        w = $clog2(v + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tone_period_lut.sv
// Lowest-index key priority encoder plus pitch lookup; yields the target
// half-period T (0 when no key is held) and the selected key index k.
module tone_period_lut
    import musicbox_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int NUM_KEYS = 16,
    parameter int BAND_W   = 3,
    parameter int IDX_W    = 4,
    parameter int PERIOD_W = 21
) (
    input  logic [NUM_KEYS-1:0] key,
    input  logic [BAND_W-1:0]   band,
    output logic [PERIOD_W-1:0] t,
    output logic [IDX_W-1:0]    k
);

    logic [PERIOD_W-1:0] base;

    always_comb begin
        base = '0;
        k    = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key[i]) begin
                base = PERIOD_W'(half_period(CLK_HZ, i, 0));
                k    = IDX_W'(i);
            end
        end
        t = base << band;
    end

endmodule

// File: rtl/tone_gen_poly.sv
// Square-wave tone generator: band register, note FSM and half-period divider.
// Optional release tail enabled with `define MUSICBOX_SUSTAIN_EN.
//
// state   | meaning
// IDLE    | silent, bell low, waiting for any key
// PLAY    | key held, bell toggles every latched half-period
// SUSTAIN | key released, tone rings on for SUSTAIN_CYC clocks
module tone_gen_poly
    import musicbox_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int NUM_KEYS    = 16,
    parameter int BAND_W      = 3,
    parameter int BAND_INIT   = 2,
    parameter int SUSTAIN_CYC = 1_000_000,
    localparam int IDX_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int PERIOD_W   = period_w(CLK_HZ, BAND_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                oct_down,
    input  logic                oct_up,
    input  logic                mute,
    output logic                bell,
    output logic [BAND_W-1:0]   band,
    output logic                active,
    output logic [IDX_W-1:0]    note_idx,
    output logic [PERIOD_W-1:0] period
);

    localparam logic [BAND_W-1:0] BAND_MAX = BAND_W'((1 << BAND_W) - 1);

    state_e              state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] t;
    logic [IDX_W-1:0]    k;
    logic                boundary;
    logic                t_zero;

    tone_period_lut #(
        .CLK_HZ   (CLK_HZ),
        .NUM_KEYS (NUM_KEYS),
        .BAND_W   (BAND_W),
        .IDX_W    (IDX_W),
        .PERIOD_W (PERIOD_W)
    ) u_lut (
        .key  (key),
        .band (band),
        .t    (t),
        .k    (k)
    );

    assign boundary = (cnt == period - PERIOD_W'(1));
    assign t_zero   = (t == '0);
    assign active   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            band <= BAND_W'(BAND_INIT);
        end else if (oct_up && !oct_down && band != BAND_MAX) begin
            band <= band + BAND_W'(1);
        end else if (oct_down && !oct_up && band != '0) begin
            band <= band - BAND_W'(1);
        end
    end

`ifdef MUSICBOX_SUSTAIN_EN
    localparam int REL_W = $clog2(SUSTAIN_CYC + 1);

    logic [REL_W-1:0] rel_cnt;
    logic             rel_done;

    assign rel_done = (rel_cnt == REL_W'(SUSTAIN_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bell     <= 1'b0;
            cnt      <= '0;
            period   <= '0;
            note_idx <= '0;
            rel_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bell    <= 1'b0;
                    cnt     <= '0;
                    rel_cnt <= '0;
                    if (!t_zero) begin
                        period   <= t;
                        note_idx <= k;
                        state    <= PLAY;
                    end
                end
                PLAY: begin
                    if (t_zero) begin
                        state   <= SUSTAIN;
                        rel_cnt <= '0;
                    end
                    if (!mute) begin
                        if (boundary) begin
                            bell <= ~bell;
                            cnt  <= '0;
                            if (!t_zero) begin
                                period   <= t;
                                note_idx <= k;
                            end
                        end else begin
                            cnt <= cnt + PERIOD_W'(1);
                        end
                    end
                end
                SUSTAIN: begin
                    if (!t_zero) begin
                        state   <= PLAY;
                        rel_cnt <= '0;
                    end else if (!mute && !rel_done) begin
                        rel_cnt <= rel_cnt + REL_W'(1);
                    end
                    if (!mute) begin
                        if (boundary) begin
                            cnt <= '0;
                            if (!t_zero) begin
                                bell     <= ~bell;
                                period   <= t;
                                note_idx <= k;
                            end else if (rel_done) begin
                                bell  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                bell <= ~bell;
                            end
                        end else begin
                            cnt <= cnt + PERIOD_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bell     <= 1'b0;
            cnt      <= '0;
            period   <= '0;
            note_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bell <= 1'b0;
                    cnt  <= '0;
                    if (!t_zero) begin
                        period   <= t;
                        note_idx <= k;
                        state    <= PLAY;
                    end
                end
                PLAY: begin
                    if (!mute) begin
                        if (boundary) begin
                            cnt <= '0;
                            if (!t_zero) begin
                                bell     <= ~bell;
                                period   <= t;
                                note_idx <= k;
                            end else begin
                                // Release always completes the half-period and ends low.
                                bell  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + PERIOD_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_tone_gen_poly.sv
// Directed bench for tone_gen_poly at CLK_HZ=37300 (key0 half-period = 10 clocks).
module tb_tone_gen_poly;
    import musicbox_pkg::*;

    localparam int CLK_HZ   = 37300;
    localparam int NUM_KEYS = 16;
    localparam int BAND_W   = 3;
    localparam int PW       = period_w(CLK_HZ, BAND_W);

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     key;
    logic            oct_down, oct_up, mute;
    logic            bell;
    logic [2:0]      band;
    logic            active;
    logic [3:0]      note_idx;
    logic [PW-1:0]   period;

    int n_cmp = 0;
    int n_err = 0;

    tone_gen_poly #(
        .CLK_HZ      (CLK_HZ),
        .NUM_KEYS    (NUM_KEYS),
        .BAND_W      (BAND_W),
        .BAND_INIT   (2),
        .SUSTAIN_CYC (30)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .oct_down (oct_down),
        .oct_up   (oct_up),
        .mute     (mute),
        .bell     (bell),
        .band     (band),
        .active   (active),
        .note_idx (note_idx),
        .period   (period)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_bell(input logic v, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bell !== v && n <= max);
    endtask

    task automatic go_idle();
        int n;
        key = '0;
        n = 0;
        while (active !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (active !== 1'b0) begin
            n_err++;
            $display("FAIL go_idle: active=%b required 0 within 3000 clocks", active);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 16'h0001; oct_up = 1'b1; oct_down = 1'b0; mute = 1'b0;
        tick(); tick();
        n_cmp++;
        if (band !== 3'd2 || bell !== 1'b0 || active !== 1'b0 || period !== '0 || note_idx !== 4'd0) begin
            n_err++;
            $display("FAIL reset: band=%0d bell=%b active=%b period=%0d idx=%0d required 2/0/0/0/0",
                     band, bell, active, period, note_idx);
        end
        rst = 1'b0; key = '0; oct_up = 1'b0;
        tick();
    endtask

    task automatic test_band_down();
        logic [2:0] exp_b [3] = '{3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 3; i++) begin
            oct_down = 1'b1; tick(); oct_down = 1'b0; tick();
            n_cmp++;
            if (band !== exp_b[i]) begin
                n_err++;
                $display("FAIL band_down[%0d]: band=%0d required %0d", i, band, exp_b[i]);
            end
        end
    endtask

    task automatic test_tone();
        int n;
        key = 16'h0001;
        tick();
        n_cmp++;
        if (active !== 1'b1 || period !== PW'(10) || note_idx !== 4'd0 || bell !== 1'b0) begin
            n_err++;
            $display("FAIL tone_start: active=%b period=%0d idx=%0d bell=%b required 1/10/0/0",
                     active, period, note_idx, bell);
        end
        n = 1;
        while (bell !== 1'b1 && n < 40) begin tick(); n++; end
        n_cmp++;
        if (n !== 11) begin n_err++; $display("FAIL first_rise: %0d clocks required 11", n); end
        count_bell(1'b0, 40, n);
        n_cmp++;
        if (n !== 10) begin n_err++; $display("FAIL half_low: %0d clocks required 10", n); end
        count_bell(1'b1, 40, n);
        n_cmp++;
        if (n !== 10) begin n_err++; $display("FAIL half_high: %0d clocks required 10", n); end
        go_idle();
    endtask

    task automatic test_key_change();
        int n;
        key = 16'h0006;
        tick();
        n_cmp++;
        if (period !== PW'(9) || note_idx !== 4'd1) begin
            n_err++;
            $display("FAIL key6: period=%0d idx=%0d required 9/1", period, note_idx);
        end
        count_bell(1'b1, 40, n);
        n_cmp++;
        if (n !== 9) begin n_err++; $display("FAIL key6_rise: %0d clocks required 9", n); end
        tick(); tick(); tick();
        key = 16'h0001;
        count_bell(1'b0, 40, n);
        n_cmp++;
        if (n + 3 !== 9 || period !== PW'(10) || note_idx !== 4'd0) begin
            n_err++;
            $display("FAIL key_switch: half=%0d period=%0d idx=%0d required 9/10/0", n + 3, period, note_idx);
        end
        count_bell(1'b1, 40, n);
        n_cmp++;
        if (n !== 10) begin n_err++; $display("FAIL after_switch: %0d clocks required 10", n); end
        go_idle();
    endtask

`ifndef MUSICBOX_SUSTAIN_EN
    task automatic test_release();
        int n;
        logic saw_high;
        key = 16'h0001;
        count_bell(1'b1, 40, n);
        key = '0;
        count_bell(1'b0, 40, n);
        n_cmp++;
        if (n !== 10 || active !== 1'b0) begin
            n_err++;
            $display("FAIL release_high: %0d clocks active=%b required 10/0", n, active);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (bell !== 1'b0 || active !== 1'b0) begin
            n_err++;
            $display("FAIL release_idle: bell=%b active=%b required 0/0", bell, active);
        end
        key = 16'h0001;
        count_bell(1'b1, 40, n);
        count_bell(1'b0, 40, n);
        key = '0;
        n = 0; saw_high = 1'b0;
        while (active !== 1'b0 && n < 40) begin
            tick(); n++;
            if (bell === 1'b1) saw_high = 1'b1;
        end
        n_cmp++;
        if (n !== 10 || saw_high !== 1'b0) begin
            n_err++;
            $display("FAIL release_low: %0d clocks bell_rose=%b required 10/0", n, saw_high);
        end
        tick();
    endtask
`else
    task automatic test_sustain();
        int n;
        key = 16'h0001;
        count_bell(1'b1, 40, n);
        count_bell(1'b0, 40, n);
        key = '0;
        for (int i = 0; i < 30; i++) tick();
        n_cmp++;
        if (active !== 1'b1) begin
            n_err++;
            $display("FAIL sustain_tail: active=%b required 1 after 30 clocks", active);
        end
        n = 0;
        while (active !== 1'b0 && n < 100) begin tick(); n++; end
        n_cmp++;
        if (active !== 1'b0 || bell !== 1'b0) begin
            n_err++;
            $display("FAIL sustain_end: active=%b bell=%b required 0/0", active, bell);
        end
        tick();
    endtask
`endif

    task automatic test_mute();
        int n;
        logic moved;
        key = 16'h0001;
        count_bell(1'b1, 40, n);
        tick(); tick(); tick(); tick();
        mute = 1'b1;
        moved = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bell !== 1'b1) moved = 1'b1;
        end
        n_cmp++;
        if (moved !== 1'b0) begin n_err++; $display("FAIL mute_hold: bell moved=%b required 0", moved); end
        mute = 1'b0;
        count_bell(1'b0, 40, n);
        n_cmp++;
        if (n !== 6) begin n_err++; $display("FAIL mute_resume: %0d clocks required 6", n); end
        go_idle();
    endtask

    task automatic test_band_up();
        int n;
        logic [2:0] exp_b;
        key = 16'h0001;
        tick();
        for (int i = 0; i < 9; i++) begin
            oct_up = 1'b1; tick(); oct_up = 1'b0; tick();
            exp_b = (i < 7) ? 3'(i + 1) : 3'd7;
            n_cmp++;
            if (band !== exp_b) begin
                n_err++;
                $display("FAIL band_up[%0d]: band=%0d required %0d", i, band, exp_b);
            end
        end
        count_bell(~bell, 3000, n);
        count_bell(~bell, 3000, n);
        n_cmp++;
        if (period !== PW'(1280)) begin n_err++; $display("FAIL period_max: %0d required 1280", period); end
        oct_up = 1'b1; oct_down = 1'b1; tick(); oct_up = 1'b0; oct_down = 1'b0; tick();
        n_cmp++;
        if (band !== 3'd7) begin n_err++; $display("FAIL both_pulses: band=%0d required 7", band); end
        oct_down = 1'b1; tick(); oct_down = 1'b0;
        count_bell(~bell, 3000, n);
        n_cmp++;
        if (band !== 3'd6 || period !== PW'(640)) begin
            n_err++;
            $display("FAIL band_down_boundary: band=%0d period=%0d required 6/640", band, period);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_band_down();
        test_tone();
        test_key_change();
`ifndef MUSICBOX_SUSTAIN_EN
        test_release();
`else
        test_sustain();
`endif
        test_mute();
        test_band_up();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
